// File: rtl/hex_ascii_encoder.sv
// hex_ascii_encoder: streams a 4*NDIGITS-bit word out as uppercase ASCII hex
// characters, most-significant nibble first, one character per tx handshake.
// Optional build macro: HEX_ASCII_CRLF_EN appends CR (8'h0D) and LF (8'h0A)
// after the last digit of every word.
module hex_ascii_encoder #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] in_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 busy
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

`ifdef HEX_ASCII_CRLF_EN
  typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DIGIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [W-1:0]    shifted;

  // Every nibble value has a character: 0-9 then A-F.
  function automatic logic [7:0] enc_nib(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  // Character valid is simply "not idle"; it therefore falls with reset.
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx_valid = busy;
  assign tx_data  = tx_data_q;

  // Next-state, next-character and shift/counter update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    shifted   = shift_q << 4;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          cnt_d     = CW'(NDIGITS - 1);
          tx_data_d = enc_nib(in_data[W-1 -: 4]);
          state_d   = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (tx_ready) begin
          if (cnt_q != '0) begin
            // Next character is loaded on the same edge as the handshake.
            cnt_d     = cnt_q - CW'(1);
            shift_d   = shifted;
            tx_data_d = enc_nib(shifted[W-1 -: 4]);
          end else begin
`ifdef HEX_ASCII_CRLF_EN
            tx_data_d = 8'h0D;
            state_d   = S_CR;
`else
            state_d   = S_IDLE;
`endif
          end
        end
      end
`ifdef HEX_ASCII_CRLF_EN
      S_CR: begin
        if (tx_ready) begin
          tx_data_d = 8'h0A;
          state_d   = S_LF;
        end
      end
      S_LF: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, shift register and output character registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_hex_ascii_encoder.sv
// Testbench for hex_ascii_encoder: table-driven words with a character
// scoreboard, plus hand-written back-to-back, stall, ignore and reset cases.
module tb_hex_ascii_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;

  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  in_data2;
  logic        tx_valid2;
  logic        tx_ready2;
  logic [7:0]  tx_data2;
  logic        busy2;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] q2[$];

  typedef struct {
    logic [15:0] word;
    logic [31:0] chars;
  } vec_t;
  vec_t vecs[8];

`ifdef HEX_ASCII_CRLF_EN
  localparam int PERIOD = 7;
`else
  localparam int PERIOD = 5;
`endif

  always #5 clk = ~clk;

  hex_ascii_encoder #(.NDIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy)
  );

  hex_ascii_encoder #(.NDIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] chars);
    for (int i = 0; i < 4; i++) q.push_back(chars[31-8*i -: 8]);
`ifdef HEX_ASCII_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
  endtask

  // Scoreboard: every accepted character must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_char", {24'h0, tx_data}, {24'h0, q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid2 && tx_ready2) begin
      if (q2.size() == 0) chk("tx2_unexpected", {24'h0, tx_data2}, 32'hFFFF_FFFF);
      else chk("tx2_char", {24'h0, tx_data2}, {24'h0, q2.pop_front()});
    end
  end

  // Call just after a rising edge; returns just after the acceptance edge.
  task automatic send(input int idx, input bit hold);
    int n;
    in_valid = 1'b1;
    in_data  = vecs[idx].word;
    push_exp(vecs[idx].chars);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("accept_timeout", n < 200, 1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1A2F, 32'h31413246};
    vecs[1] = '{16'h0000, 32'h30303030};
    vecs[2] = '{16'hFFFF, 32'h46464646};
    vecs[3] = '{16'h9C05, 32'h39433035};
    vecs[4] = '{16'h0001, 32'h30303031};
    vecs[5] = '{16'hABCD, 32'h41424344};
    vecs[6] = '{16'h5678, 32'h35363738};
    vecs[7] = '{16'h3E8B, 32'h33453842};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tx_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; tx_ready2 = 1'b1;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: every word in turn, first character the cycle after acceptance.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      send(v, 1'b0);
      chk("first_valid", tx_valid, 1);
      chk("first_char", tx_data, vecs[v].chars[31:24]);
      $display("word %h sent", vecs[v].word);
      wait_idle();
    end

    // Back-to-back 0000 then FFFF with in_valid held high.
    @(posedge clk); #1;
    send(1, 1'b1);
    in_data = vecs[2].word;
    push_exp(vecs[2].chars);
    begin
      int n;
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        n++;
        if (in_ready) break;
      end
      chk("b2b_period", n, PERIOD);
    end
    @(negedge clk);
    chk("b2b_ready_one_cycle", in_ready, 0);
    in_valid = 1'b0;
    wait_idle();

    // Stall each character of 9C05 for three cycles.
    @(posedge clk); #1;
    tx_ready = 1'b0;
    send(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (3) begin
        @(negedge clk);
        chk("stall_char", tx_data, vecs[3].chars[31-8*i -: 8]);
        chk("stall_busy", busy, 1);
        chk("stall_valid", tx_valid, 1);
      end
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle();

    // in_valid pulsed mid-word must be ignored.
    @(posedge clk); #1;
    send(6, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    chk("midword_in_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("midword_not_captured", busy, 0);

    // Reset after the second character of ABCD.
    @(posedge clk); #1;
    send(5, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    send(4, 1'b0);
    wait_idle();

    // Two-digit instance: E7 -> "E7".
    @(posedge clk); #1;
    in_valid2 = 1'b1;
    in_data2  = 8'hE7;
    q2.push_back(8'h45);
    q2.push_back(8'h37);
`ifdef HEX_ASCII_CRLF_EN
    q2.push_back(8'h0D);
    q2.push_back(8'h0A);
`endif
    @(negedge clk);
    chk("n2_ready", in_ready2, 1);
    @(posedge clk); #1 in_valid2 = 1'b0;
    chk("n2_first_char", tx_data2, 8'h45);
    begin
      int n;
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        if (!busy2) break;
        n++;
      end
    end
    chk("n2_idle", busy2, 0);
    chk("n2_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_ascii_encoder.md
# hex_ascii_encoder

Streams a binary word out as uppercase ASCII hex characters, most-significant nibble first, one byte per handshake. It sits between the CPU's debug/display datapath and the UART transmitter, and is the transmit-side counterpart of the ASCII-hex-to-nibble decoding on the receive path. Digits use '0'–'9' (8'h30–8'h39) and 'A'–'F' (8'h41–8'h46). An optional CR LF trailer can follow each word.

## Interface
Parameters:
- NDIGITS, 4, number of hex digits per word; the word width is 4*NDIGITS bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  word available on in_data
- in_ready  out  1  encoder can accept a word; high only in IDLE
- in_data  in  4*NDIGITS  binary word to encode
- tx_valid  out  1  tx_data holds a character for the UART
- tx_ready  in  1  UART accepts the character this cycle
- tx_data  out  8  ASCII character, registered
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, DIGIT, CR, LF. CR and LF exist only when HEX_ASCII_CRLF_EN is defined.
- **IDLE**
  - in_ready=1, tx_valid=0.
  - When in_valid && in_ready: capture in_data into a shift register and set the digit counter to NDIGITS-1.
  - Load tx_data with the encoding of the top nibble, set tx_valid=1, go to DIGIT.
- **DIGIT**
  - tx_valid=1, and tx_data holds the encoding of the current nibble.
  - On tx_valid && tx_ready with counter>0: decrement the counter, shift the word left by 4, and load the next character in the same edge.
  - On a handshake with counter==0: go to CR if the macro is defined; otherwise go to IDLE with tx_valid=0.
- **CR**: tx_data=8'h0D, tx_valid=1. Handshake → LF.
- **LF**: tx_data=8'h0A, tx_valid=1. Handshake → IDLE with tx_valid=0.
- Nibble encoding:
  - n<10 → 8'h30+n.
  - n≥10 → 8'h37+n, giving 'A'–'F'.
  - All 16 values map; there is no invalid code.
- in_valid outside IDLE is ignored. There is no queuing, so the source must hold in_valid until in_ready.
- busy = (state != IDLE).

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, in_ready=1, tx_valid=0, tx_data=8'h00, busy=0, counter=0, shift register=0.
- Latency: a word accepted at edge N puts its first character on tx_data with tx_valid=1 from cycle N+1.
- While tx_valid=1 and tx_ready=0, tx_data and the state hold indefinitely.
- tx_valid never drops without a handshake, except on reset.
- With tx_ready tied high, each handshake advances one character per cycle:
  - Without CRLF: a word occupies NDIGITS cycles in DIGIT, then 1 cycle in IDLE before the next acceptance. The minimum period is NDIGITS+1 cycles.
  - With CRLF: the minimum period is NDIGITS+3 cycles.
- The final handshake at edge M returns the state to IDLE. in_ready is high during cycle M+1, and a new word can be accepted at edge M+1.
- Reset asserted mid-word:
  - tx_valid drops immediately (asynchronously), and the partial word is discarded.
  - After rst_n deasserts, the encoder is in IDLE with in_ready=1.
- Simultaneous in_valid and an outstanding character: in_valid is ignored until IDLE.

## Configuration
- Macro `HEX_ASCII_CRLF_EN`:
  - Defined: after the last digit, 8'h0D then 8'h0A are sent, each with its own tx handshake, before returning to IDLE.
  - Undefined: the CR and LF states and their logic are not compiled, and the last digit handshake returns directly to IDLE.

## Test plan
- Encode 16'h1A2F, tx_ready=1:
  - Expect tx_data sequence 8'h31, 8'h41, 8'h32, 8'h46, with CRLF_EN followed by 8'h0D, 8'h0A.
  - The first character appears the cycle after acceptance.
- Encode 16'h0000 then 16'hFFFF back-to-back, with in_valid held high:
  - Expect 30 30 30 30, then 46 46 46 46.
  - in_ready is high for exactly one cycle between the two words.
  - The period is 5 cycles without CRLF, 7 with.
- Encode 16'h9C05 with tx_ready=0 for 3 cycles on each character:
  - Each character holds stable while stalled; the sequence is 39 43 30 35.
  - busy stays 1 throughout.
- Pulse in_valid with 16'h1234 while the encoder is mid-word (busy=1):
  - The word is not captured, in_ready stays 0, and the current word completes unchanged.
- Assert rst_n=0 after the second character of 16'hABCD:
  - tx_valid=0 and tx_data=8'h00 immediately, and in_ready=1 after release.
  - A subsequent 16'h0001 emits 30 30 30 31.
- Run with NDIGITS=2, encoding 8'hE7: expect 45 37.
